core_run_ctrl: RTL and testbench

Parametrised run controller for the single-cycle core. It replaces the fixed "done when PC hits 128" check with a full program-run sequencer. On a `req` handshake it selects one of `P` programs and loads that program's start address into the PC. It then enables the core until a halt instruction, the program's end address, or a cycle-budget timeout, and reports the run length. It also owns the core's registered ALU flags (shift/carry, parity, zero), which are frozen whenever the core is not running. It sits between the top level's `req`/`done` pins and the PC, PC_LUT and ALU.

---
 rtl/core_run_ctrl.sv | 157 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : core_run_ctrl
// Brief    : Program-run sequencer for the single-cycle core. Selects one of
//            P programs on a req handshake, loads its start address into the
//            PC, and then enables the core until a halt, the end address or a
//            cycle-budget timeout. It reports the run length and owns the
//            registered ALU flags, which are frozen while the core is idle.
// Revision : 1.0 - initial release
// ============================================================================
module core_run_ctrl #(
  parameter int D   = 12,    // program counter width
  parameter int P   = 4,     // number of selectable programs (1..16)
  parameter int W   = 16,    // cycle counter width
  parameter int TMO = 4096   // cycle budget per run (1..2^W-1)
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active-low
  input  logic             req,
  input  logic [3:0]       prog_sel,
  input  logic [P*D-1:0]   start_addr,
  input  logic [P*D-1:0]   end_addr,
  input  logic [D-1:0]     prog_ctr,
  input  logic             halt,
  input  logic             sc_o,
  input  logic             sc_en,
  input  logic             sc_clr,
  input  logic             pari,
  input  logic             zero,
  output logic             pc_load,
  output logic [D-1:0]     pc_target,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [W-1:0]     cycles,
  output logic             sc_q,
  output logic             pari_q,
  output logic             zero_q
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0]   c_num_prog = 5'(P);
  localparam logic [W-1:0] c_tmo_last = W'(TMO - 1);

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_sel;
  logic         w_accept;
  logic         w_stop;
  logic         w_tmo_hit;
  logic [D-1:0] w_start;
  logic [D-1:0] w_end;

  // Selected program's address window; r_sel is always a valid index.
  assign w_start = start_addr[32'(r_sel) * D +: D];
  assign w_end   = end_addr[32'(r_sel) * D +: D];

  // A halt or the end address ends the run without executing that instruction.
  assign w_stop = halt | (prog_ctr == w_end);

  // Next-state and state-decoded outputs; run_en is the only path from inputs.
  always_comb begin
    w_next    = r_state;
    pc_load   = 1'b0;
    pc_target = '0;
    run_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    w_accept  = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        done = (r_state == ST_DONE);
        if (req && ({1'b0, prog_sel} < c_num_prog)) begin
          w_accept = 1'b1;
          w_next   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pc_load   = 1'b1;
        pc_target = w_start;
        busy      = 1'b1;
        w_next    = ST_RUN;
      end
      ST_RUN: begin
        busy   = 1'b1;
        run_en = ~w_stop;
        if (w_stop) begin
          w_next = ST_DONE;
        end else if (cycles == c_tmo_last) begin
          w_tmo_hit = 1'b1;
          w_next    = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Program selection, run-length counter and timeout status; all cleared on accept
  // so the LOAD cycle already shows a fresh run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel   <= '0;
      cycles  <= '0;
      timeout <= 1'b0;
    end else if (w_accept) begin
      r_sel   <= prog_sel;
      cycles  <= '0;
      timeout <= 1'b0;
    end else if (r_state == ST_RUN) begin
      cycles <= cycles + W'(1);
      if (w_tmo_hit) begin
        timeout <= 1'b1;
      end
    end
  end

  // ALU flags advance only with executed instructions; a new run starts them at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc_q   <= 1'b0;
      pari_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (w_accept) begin
      sc_q   <= 1'b0;
      pari_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (run_en) begin
      if (sc_clr) begin
        sc_q <= 1'b0;
      end else if (sc_en) begin
        sc_q <= sc_o;
      end
      pari_q <= pari;
      zero_q <= zero;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_core_run_ctrl
// Brief    : Scoreboard bench for core_run_ctrl with a PC model, a per-address
//            instruction flag table and a run-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_run_ctrl;

  localparam int D   = 12;
  localparam int P   = 3;
  localparam int W   = 16;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req = 1'b0;
  logic [3:0]     prog_sel = 4'd0;
  logic [P*D-1:0] start_addr = '0;
  logic [P*D-1:0] end_addr = '0;
  logic [D-1:0]   pc = '0;
  logic           halt;
  logic           sc_o, sc_en, sc_clr, pari, zero;
  logic           pc_load, run_en, busy, done, timeout;
  logic [D-1:0]   pc_target;
  logic [W-1:0]   cycles;
  logic           sc_q, pari_q, zero_q;

  // Flag inputs: from a per-address table while a run is active, random otherwise.
  logic [4:0]     ftbl [0:4095];
  logic           phase_run = 1'b0;
  logic [4:0]     rnd_flags = 5'd0;
  logic [4:0]     fin;
  logic           halt_en = 1'b0;
  logic [D-1:0]   halt_addr = '0;

  assign fin    = phase_run ? ftbl[pc] : rnd_flags;
  assign sc_o   = fin[4];
  assign sc_en  = fin[3];
  assign sc_clr = fin[2];
  assign pari   = fin[1];
  assign zero   = fin[0];
  assign halt   = halt_en && (pc == halt_addr);

  core_run_ctrl #(.D(D), .P(P), .W(W), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
    .start_addr(start_addr), .end_addr(end_addr), .prog_ctr(pc), .halt(halt),
    .sc_o(sc_o), .sc_en(sc_en), .sc_clr(sc_clr), .pari(pari), .zero(zero),
    .pc_load(pc_load), .pc_target(pc_target), .run_en(run_en), .busy(busy),
    .done(done), .timeout(timeout), .cycles(cycles),
    .sc_q(sc_q), .pari_q(pari_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  // Simple fetch PC: loads on pc_load, advances on run_en.
  always @(posedge clk) begin
    if (pc_load) pc <= pc_target;
    else if (run_en) pc <= pc + D'(1);
  end

  typedef struct {
    logic [W-1:0] cyc;
    logic         to;
    logic [2:0]   flags;   // {sc, pari, zero}
    int           execs;
    logic [D-1:0] tgt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  // Reference: walk the program address by address; stop before executing
  // an end/halt address, or after TMO executed instructions.
  function automatic exp_t model(input logic [D-1:0] s, input logic [D-1:0] e,
                                 input logic hen, input logic [D-1:0] ha);
    exp_t x;
    logic [D-1:0] a;
    logic [4:0] f;
    logic sc, pr, zr;
    sc = 1'b0; pr = 1'b0; zr = 1'b0;
    x.tgt = s; x.to = 1'b0; x.execs = 0; x.cyc = '0;
    for (int i = 0; i < TMO; i++) begin
      a = s + D'(i);
      if (a == e || (hen && a == ha)) begin
        x.cyc = W'(i + 1);
        break;
      end
      f = ftbl[a];
      if (f[2]) sc = 1'b0;
      else if (f[3]) sc = f[4];
      pr = f[1];
      zr = f[0];
      x.execs++;
      if (i == TMO - 1) begin
        x.cyc = W'(TMO);
        x.to  = 1'b1;
      end
    end
    x.flags = {sc, pr, zr};
    return x;
  endfunction

  // Monitor: tallies loads and executed cycles, checks each finished run.
  int           n_load = 0;
  int           n_run = 0;
  logic [D-1:0] seen_tgt = '0;
  logic         prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      n_load = 0; n_run = 0; prev_done = 1'b0;
    end else begin
      if (pc_load) begin n_load++; seen_tgt = pc_target; end
      if (run_en) n_run++;
      if (done && !prev_done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("cycles", 32'(cycles), 32'(e.cyc));
          chk("timeout", 32'(timeout), 32'(e.to));
          chk("flags", 32'({sc_q, pari_q, zero_q}), 32'(e.flags));
          chk("run_en_count", 32'(n_run), 32'(e.execs));
          chk("pc_load_count", 32'(n_load), 32'd1);
          chk("pc_target", 32'(seen_tgt), 32'(e.tgt));
        end
        n_load = 0; n_run = 0;
      end
      prev_done = done;
    end
  end

  // One run: program, request, optional ignored mid-run req, wait for done,
  // then an idle period with toggling flags and invalid requests.
  task automatic run_prog(input int sel, input logic [D-1:0] s, input logic [D-1:0] e,
                          input logic hen, input logic [D-1:0] ha, input bit poke);
    exp_t x;
    bit got;
    start_addr[sel*D +: D] = s;
    end_addr[sel*D +: D]   = e;
    halt_en   = hen;
    halt_addr = ha;
    x = model(s, e, hen, ha);
    sbq.push_back(x);
    @(negedge clk);
    req = 1'b1; prog_sel = 4'(sel); phase_run = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (n == 0) chk("timeout_cleared", 32'(timeout), 32'd0);
      if (done) begin got = 1'b1; break; end
      if (poke && n == 0 && busy) begin
        req = 1'b1; prog_sel = 4'($urandom_range(0, P - 1));
      end
    end
    req = 1'b0;
    if (!got) begin
      chk("done_wait", 32'd0, 32'd1);
      sbq.delete();
    end
    phase_run = 1'b0;
    halt_en   = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      rnd_flags = 5'($urandom);
      req = ($urandom_range(0, 1) == 1);
      prog_sel = 4'($urandom_range(P, 15));
    end
    @(negedge clk);
    req = 1'b0;
    chk("flags_hold", 32'({sc_q, pari_q, zero_q}), 32'(x.flags));
    chk("done_hold", 32'({done, busy}), 32'b10);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 4096; i++) ftbl[i] = 5'($urandom);
    #12;
    chk("rst_ctrl", 32'({pc_load, run_en, busy, done, timeout, sc_q, pari_q, zero_q}), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_target", 32'(pc_target), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Out-of-range program index is ignored in IDLE.
    @(negedge clk); req = 1'b1; prog_sel = 4'd3;
    @(negedge clk); prog_sel = 4'd15;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("bad_sel_state", 32'({busy, done}), 32'd0);
    chk("bad_sel_noload", 32'(n_load), 32'd0);

    // Directed: end-address stop, halt stop, timeout then clean restart.
    run_prog(2, 12'h040, 12'h045, 1'b0, 12'h000, 1'b0);
    run_prog(2, 12'h040, 12'h045, 1'b1, 12'h042, 1'b1);
    run_prog(1, 12'h100, 12'h0FF, 1'b0, 12'h000, 1'b0);
    run_prog(0, 12'h200, 12'h200, 1'b0, 12'h000, 1'b0);

    // Reset in the middle of a run.
    start_addr[0 +: D] = 12'h300;
    end_addr[0 +: D]   = 12'h2FF;
    @(negedge clk); req = 1'b1; prog_sel = 4'd0; phase_run = 1'b1;
    @(negedge clk); req = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cycles == W'(5)) begin ok = 1'b1; break; end
    end
    chk("reach_cycles5", 32'(ok), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({pc_load, run_en, busy, done, timeout, sc_q, pari_q, zero_q}), 32'd0);
    chk("midrst_cycles", 32'(cycles), 32'd0);
    sbq.delete();
    phase_run = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b1;
    run_prog(2, 12'h040, 12'h045, 1'b0, 12'h000, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      logic [D-1:0] s, e, ha;
      s  = D'($urandom);
      e  = ($urandom_range(0, 3) == 0) ? s - D'(1) : s + D'($urandom_range(0, 10));
      ha = s + D'($urandom_range(0, 10));
      run_prog($urandom_range(0, P - 1), s, e, 1'($urandom_range(0, 1)), ha,
               1'($urandom_range(0, 1)));
    end

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
